// File: rtl/hsv2rgb_share_arb.sv
// Round-robin arbiter that lets NUM_REQ colour requesters share one pipelined
// HSV-to-RGB converter. Requester indices travel alongside the converter in a
// tag pipe, and each RGB result is returned to its owner as a one-hot strobe.
// A sticky error flag is set if the converter's result strobe ever disagrees
// with the tag pipe.
module hsv2rgb_share_arb #(
  parameter  int NUM_REQ  = 4,
  parameter  int CONV_LAT = 4,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [24*NUM_REQ-1:0]  req_hsv,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   pause,
  output logic                   conv_in_valid,
  output logic [23:0]            conv_hsv,
  input  logic                   conv_out_valid,
  input  logic [23:0]            conv_rgb,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [23:0]            rsp_rgb,
  output logic [IDX_W+2:0]       in_flight,
  output logic                   err
);

  localparam int CNT_W = IDX_W + 3;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic             accept;
  logic [IDX_W-1:0] issue_idx;

  logic [CONV_LAT-1:0] tag_v;
  logic [IDX_W-1:0]    tag_idx [CONV_LAT];
  logic                head_v;
  logic [IDX_W-1:0]    head_idx;

  // Requester index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  // Pick the first pending requester at or after the round-robin pointer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    req_ready   = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    if (!rst && !pause) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_found && req_valid[wrap_idx(int'(ptr) + k)]) begin
          grant_found = 1'b1;
          grant_idx   = wrap_idx(int'(ptr) + k);
        end
      end
    end
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign accept   = grant_found;
  assign head_v   = tag_v[CONV_LAT-1];
  assign head_idx = tag_idx[CONV_LAT-1];

  // Pointer, issue register, tag valid bits, response steering and bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      ptr           <= '0;
      conv_in_valid <= 1'b0;
      conv_hsv      <= '0;
      issue_idx     <= '0;
      tag_v         <= '0;
      rsp_valid     <= '0;
      rsp_rgb       <= '0;
      in_flight     <= '0;
      err           <= 1'b0;
    end else begin
      conv_in_valid <= accept;
      if (accept) begin
        ptr       <= wrap_idx(int'(grant_idx) + 1);
        conv_hsv  <= req_hsv[int'(grant_idx)*24 +: 24];
        issue_idx <= grant_idx;
      end

      tag_v[0] <= conv_in_valid;
      for (int i = 1; i < CONV_LAT; i++) tag_v[i] <= tag_v[i-1];

      rsp_valid <= '0;
      if (head_v && conv_out_valid) begin
        rsp_valid[head_idx] <= 1'b1;
        rsp_rgb             <= conv_rgb;
      end
      // A tag without a result, or a result without a tag: both are dropped.
      if (head_v != conv_out_valid) err <= 1'b1;

      // Every valid head tag retires this cycle, matched or not.
      if (accept && !head_v)      in_flight <= in_flight + CNT_W'(1);
      else if (!accept && head_v) in_flight <= in_flight - CNT_W'(1);
    end
  end

  // Requester index payload of the tag pipe, shifted in lockstep with tag_v.
  always_ff @(posedge clk) begin
    // NOTE: the index payload is not reset; it is only consumed when its
    // valid bit (which is reset) is set.
    tag_idx[0] <= issue_idx;
    for (int i = 1; i < CONV_LAT; i++) tag_idx[i] <= tag_idx[i-1];
  end

endmodule

// File: tb/tb_hsv2rgb_share_arb.sv
// Self-checking bench for hsv2rgb_share_arb. A behavioural converter stub sits
// on the conv_* ports; a queue-based model predicts every output each cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_hsv2rgb_share_arb;

  localparam int NUM_REQ  = 4;
  localparam int CONV_LAT = 4;
  localparam int IDX_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [24*NUM_REQ-1:0] req_hsv;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  pause;
  logic                  conv_in_valid;
  logic [23:0]           conv_hsv;
  logic                  conv_out_valid;
  logic [23:0]           conv_rgb;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [23:0]           rsp_rgb;
  logic [IDX_W+2:0]      in_flight;
  logic                  err;
  logic                  inject;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hsv2rgb_share_arb #(.NUM_REQ(NUM_REQ), .CONV_LAT(CONV_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_hsv        (req_hsv),
    .req_ready      (req_ready),
    .pause          (pause),
    .conv_in_valid  (conv_in_valid),
    .conv_hsv       (conv_hsv),
    .conv_out_valid (conv_out_valid),
    .conv_rgb       (conv_rgb),
    .rsp_valid      (rsp_valid),
    .rsp_rgb        (rsp_rgb),
    .in_flight      (in_flight),
    .err            (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Six-sector integer HSV to RGB.
  function automatic logic [23:0] hsv2rgb(input logic [23:0] hsv);
    int h, s, v, region, rem, p, q, t, r, g, b;
    h = int'(hsv[23:16]); s = int'(hsv[15:8]); v = int'(hsv[7:0]);
    region = h / 43;
    rem = (h - region * 43) * 6;
    p = (v * (255 - s)) >> 8;
    q = (v * (255 - ((s * rem) >> 8))) >> 8;
    t = (v * (255 - ((s * (255 - rem)) >> 8))) >> 8;
    case (region)
      0:       begin r = v; g = t; b = p; end
      1:       begin r = q; g = v; b = p; end
      2:       begin r = p; g = v; b = t; end
      3:       begin r = p; g = q; b = v; end
      4:       begin r = t; g = p; b = v; end
      default: begin r = v; g = p; b = q; end
    endcase
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  // Converter stub: fixed CONV_LAT latency, reset by the shared rst.
  logic [CONV_LAT-1:0] cv_v;
  logic [23:0]         cv_rgb [CONV_LAT];
  always @(posedge clk) begin
    if (rst) cv_v <= '0;
    else begin
      cv_v[0] <= conv_in_valid;
      for (int i = 1; i < CONV_LAT; i++) cv_v[i] <= cv_v[i-1];
    end
    cv_rgb[0] <= hsv2rgb(conv_hsv);
    for (int i = 1; i < CONV_LAT; i++) cv_rgb[i] <= cv_rgb[i-1];
  end
  assign conv_out_valid = cv_v[CONV_LAT-1] | inject;
  assign conv_rgb       = cv_rgb[CONV_LAT-1];

  // Reference model: a list of accepted requests with their accept cycles.
  typedef struct {
    int          cyc;
    int          idx;
    logic [23:0] hsv;
  } acc_t;

  acc_t               acc_q[$];
  int                 mptr;
  bit                 model_on = 1'b0;
  logic               exp_civ;
  logic [23:0]        exp_chsv;
  logic [NUM_REQ-1:0] exp_rsp_v;
  logic [23:0]        exp_rsp_rgb;
  logic               exp_err;

  always @(negedge clk) begin : monitor
    int m, g, infl, head_k, cand;
    logic [NUM_REQ-1:0] exp_ready;
    acc_t a;
    m = cyc;
    g = -1;
    exp_ready = '0;
    if (!rst && !pause) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (mptr + k) % NUM_REQ;
        if (g < 0 && req_valid[cand]) g = cand;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;

    if (model_on) begin
      infl = 0;
      foreach (acc_q[i])
        if (m - acc_q[i].cyc >= 1 && m - acc_q[i].cyc <= CONV_LAT + 1) infl++;
      check("req_ready",     32'(req_ready),     32'(exp_ready));
      check("conv_in_valid", 32'(conv_in_valid), 32'(exp_civ));
      check("conv_hsv",      32'(conv_hsv),      32'(exp_chsv));
      check("rsp_valid",     32'(rsp_valid),     32'(exp_rsp_v));
      check("rsp_rgb",       32'(rsp_rgb),       32'(exp_rsp_rgb));
      check("in_flight",     32'(in_flight),     32'(infl));
      check("err",           32'(err),           32'(exp_err));
    end

    if (rst) begin
      acc_q.delete();
      mptr = 0;
      exp_civ = 1'b0; exp_chsv = '0;
      exp_rsp_v = '0; exp_rsp_rgb = '0; exp_err = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      head_k = -1;
      foreach (acc_q[i]) if (acc_q[i].cyc == m - 1 - CONV_LAT) head_k = i;
      exp_rsp_v = '0;
      if (head_k >= 0 && conv_out_valid) begin
        exp_rsp_v[acc_q[head_k].idx] = 1'b1;
        exp_rsp_rgb = hsv2rgb(acc_q[head_k].hsv);
      end
      if ((head_k >= 0) != conv_out_valid) exp_err = 1'b1;
      exp_civ = (g >= 0);
      if (g >= 0) begin
        a.cyc = m; a.idx = g; a.hsv = req_hsv[24*g +: 24];
        acc_q.push_back(a);
        exp_chsv = a.hsv;
        mptr = (g + 1) % NUM_REQ;
      end
      while (acc_q.size() > 0 && acc_q[0].cyc < m - CONV_LAT) void'(acc_q.pop_front());
    end
  end

  // Running count of response strobes per requester.
  int rsp_cnt [NUM_REQ];
  initial foreach (rsp_cnt[i]) rsp_cnt[i] = 0;
  always @(negedge clk)
    if (rst === 1'b0)
      for (int i = 0; i < NUM_REQ; i++) if (rsp_valid[i] === 1'b1) rsp_cnt[i]++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; pause = 1'b0; inject = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic skip_rsp_check();
    if (rsp_valid == 4'b0010) check("skip_rgb_req1", 32'(rsp_rgb), 32'h03FF00);
    if (rsp_valid == 4'b1000) check("skip_rgb_req3", 32'(rsp_rgb), 32'h0009FF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base [NUM_REQ];
    int tot;
    logic [NUM_REQ-1:0] acc;

    rst = 1'b1; req_valid = '0; req_hsv = '0; pause = 1'b0; inject = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Single request from requester 2.
    do_reset();
    req_hsv[2*24 +: 24] = 24'h00FFFF;
    req_valid = 4'b0100;
    @(negedge clk); check("single_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    @(negedge clk);
    check("single_civ",  32'(conv_in_valid), 32'h1);
    check("single_chsv", 32'(conv_hsv), 32'h00FFFF);
    check("single_infl", 32'(in_flight), 32'h1);
    repeat (4) tick();
    @(negedge clk); check("single_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    @(negedge clk);
    check("single_rsp", 32'(rsp_valid), 32'h4);
    check("single_rgb", 32'(rsp_rgb), 32'hFF0000);
    check("single_infl_zero", 32'(in_flight), 32'h0);

    // Fairness with all four requesters pending.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_hsv[i*24 +: 24] = 24'($urandom);
      base[i] = rsp_cnt[i];
    end
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); check("fair_grant", 32'(req_ready), 32'(1) << (k % 4));
      tick();
    end
    req_valid = '0;
    repeat (10) tick();
    for (int i = 0; i < NUM_REQ; i++) check("fair_rsp_count", 32'(rsp_cnt[i] - base[i]), 32'd3);

    // Idle requesters are skipped.
    do_reset();
    req_hsv[1*24 +: 24] = 24'h55FFFF;
    req_hsv[3*24 +: 24] = 24'hAAFFFF;
    for (int i = 0; i < NUM_REQ; i++) base[i] = rsp_cnt[i];
    req_valid = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("skip_grant", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      skip_rsp_check();
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); skip_rsp_check();
      tick();
    end
    check("skip_cnt_req1", 32'(rsp_cnt[1] - base[1]), 32'd4);
    check("skip_cnt_req3", 32'(rsp_cnt[3] - base[3]), 32'd4);
    check("skip_cnt_req0", 32'(rsp_cnt[0] - base[0]), 32'd0);

    // Pause after four accepts (grants 1,2,3,1 leave the pointer at 2).
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_hsv[i*24 +: 24] = 24'($urandom);
    req_valid = 4'b1110;
    repeat (4) begin @(negedge clk); tick(); end
    pause = 1'b1;
    tot = 0;
    for (int i = 0; i < NUM_REQ; i++) tot -= rsp_cnt[i];
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("pause_ready", 32'(req_ready), 32'h0);
      if (k == 0) check("pause_infl_full", 32'(in_flight), 32'd4);
      if (k == 9) check("pause_infl_empty", 32'(in_flight), 32'd0);
      tick();
    end
    for (int i = 0; i < NUM_REQ; i++) tot += rsp_cnt[i];
    check("pause_rsp_total", 32'(tot), 32'd4);
    pause = 1'b0;
    @(negedge clk); check("pause_resume_grant", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    repeat (8) tick();

    // Result strobe with an empty tag pipe.
    do_reset();
    inject = 1'b1;
    tick(); inject = 1'b0;
    @(negedge clk);
    check("mismatch_err", 32'(err), 32'h1);
    check("mismatch_no_rsp", 32'(rsp_valid), 32'h0);
    repeat (5) begin tick(); @(negedge clk); check("mismatch_sticky", 32'(err), 32'h1); end
    do_reset();
    @(negedge clk); check("mismatch_cleared", 32'(err), 32'h0);

    // Reset with three requests outstanding.
    do_reset();
    req_valid = 4'b0111;
    repeat (3) begin @(negedge clk); tick(); end
    req_valid = '0; rst = 1'b1;
    @(negedge clk); check("rstmid_ready", 32'(req_ready), 32'h0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rstmid_civ",  32'(conv_in_valid), 32'h0);
    check("rstmid_chsv", 32'(conv_hsv), 32'h0);
    check("rstmid_infl", 32'(in_flight), 32'h0);
    check("rstmid_rgb",  32'(rsp_rgb), 32'h0);
    check("rstmid_err",  32'(err), 32'h0);
    for (int k = 0; k < 2*CONV_LAT; k++) begin
      check("rstmid_no_rsp", 32'(rsp_valid), 32'h0);
      tick(); @(negedge clk);
    end

    // Randomized traffic with pauses and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          req_hsv[i*24 +: 24] = 24'($urandom);
        end
      end
      pause = ($urandom_range(0, 99) < 10);
      rst   = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; pause = 1'b0; req_valid = '0;
    repeat (12) tick();
    @(negedge clk);
    check("final_infl", 32'(in_flight), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hsv2rgb_share_arb.md
Name: hsv2rgb_share_arb

Overview:
- Round-robin arbiter that shares one pipelined HSV-to-RGB converter (hsv2rgb_8u, fixed latency) among NUM_REQ independent colour requesters, e.g. several LED/PWM channels.
- Accepts one HSV request per cycle and issues it to the converter.
- Carries the requester index through a tag shift register matched to the converter latency, then steers each RGB result back to its requester as a one-hot strobe.
- Also checks that the converter's out_valid timing matches the tag pipeline, and flags any mismatch.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CONV_LAT, 4, converter latency in cycles from in_valid to out_valid (4 for hsv2rgb_8u).
- IDX_W, $clog2(NUM_REQ), tag width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high. Also drives the converter's rst.
- req_valid  in  NUM_REQ  per-requester request.
- req_hsv  in  24*NUM_REQ  packed {H,S,V}; requester i uses bits [24i+23:24i].
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational.
- pause  in  1  when 1, no new grants; in-flight results still drain.
- conv_in_valid  out  1  registered issue strobe to the converter.
- conv_hsv  out  24  registered HSV to the converter.
- conv_out_valid  in  1  converter result strobe.
- conv_rgb  in  24  converter result {R,G,B}.
- rsp_valid  out  NUM_REQ  registered one-hot result strobe.
- rsp_rgb  out  24  registered result, valid when any rsp_valid bit is set.
- in_flight  out  IDX_W+3  count of issued, not-yet-returned requests.
- err  out  1  sticky tag/valid mismatch flag; cleared only by rst.

Behaviour:
- Reset values (registered outputs):
  - conv_in_valid=0, conv_hsv=0.
  - rsp_valid=0, rsp_rgb=0.
  - in_flight=0, err=0.
  - RR pointer=0; all tag-pipe entries invalid.
  - req_ready is forced to 0 while rst=1.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i]=1, searching from ptr upward modulo NUM_REQ.
  - No grant when pause=1 or no requests are pending.
  - req_ready = grant vector; at most one bit is set.
  - A request is accepted when req_valid[i] & req_ready[i].
  - Requesters hold req_valid and req_hsv stable until accepted. The arbiter never withdraws ready from an unaccepted requester within a cycle.
- Pointer update: on accept of index g, ptr <= (g+1) mod NUM_REQ. Otherwise ptr holds.
- Issue: on accept, the next cycle has conv_in_valid=1 and conv_hsv=req_hsv[g]. Otherwise conv_in_valid=0 and conv_hsv holds.
- Tag pipe:
  - CONV_LAT entries of {valid, idx}.
  - Entry 0 is loaded with {conv_in_valid, registered g} each cycle; entries shift every cycle.
  - The head is the entry aligned with conv_out_valid.
- Return (registered, 1 cycle after conv_out_valid):
  - If the head is valid and conv_out_valid=1: rsp_valid[head.idx]=1 and rsp_rgb=conv_rgb.
  - If the head is valid and conv_out_valid=0: err<=1, tag dropped, no rsp.
  - If the head is invalid and conv_out_valid=1: err<=1, result dropped, no rsp.
  - In every other cycle rsp_valid=0 and rsp_rgb holds.
- Latency: accept at cycle T gives conv_in_valid at T+1 and rsp_valid at T+1+CONV_LAT+1.
- Throughput: 1 request per cycle sustained; no backpressure on responses.
- in_flight:
  - +1 on each accept; -1 when a head tag retires (matched or dropped).
  - When both occur in the same cycle, it holds.
  - Never exceeds CONV_LAT+1.
- pause: asserting it mid-stream stops new grants from that cycle. Issued requests complete normally. ptr is unchanged while paused.
- Reset mid-operation: all in-flight tags are discarded and no rsp is produced for them. The converter is reset by the same rst, so no stale conv_out_valid may follow.
- Single requester: it is granted every cycle it is valid, and ptr still advances.

Test Plan:
- Reset then single request: req_valid[2]=1, hsv=0x00FFFF. req_ready[2] goes high the same cycle. conv_in_valid at T+1. rsp_valid=4'b0100 at T+6 with rsp_rgb=0xFF0000. in_flight returns to 0.
- Fairness: all 4 requesters held valid for 12 cycles → grant order 0,1,2,3,0,1,2,3,0,1,2,3. Each gets 3 rsp strobes in the same order, CONV_LAT+2 cycles after accept.
- Skip idle: req_valid=4'b1010 with ptr=0 → grants 1,3,1,3,… The two requesters' distinct hsv values come back to the correct index: 0x55FFFF (H=85) → green-dominant; 0xAAFFFF (H=170) → blue-dominant.
- Pause: 4 requests accepted, pause=1 for 10 cycles → no req_ready during pause. The 4 rsp strobes still appear. in_flight counts 4→0, and ptr is unchanged after pause drops.
- Mismatch: inject conv_out_valid=1 with an empty tag pipe → err=1 next cycle, no rsp_valid. err stays 1 until rst.
- Reset mid-flight: 3 requests outstanding, pulse rst for 1 cycle → all outputs return to reset values. No rsp_valid in the following 2*CONV_LAT cycles. err=0.
